// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register bank.
// Grants one requester, commits its data, acks it, then holds off HOLD cycles.
module shared_reg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     wdata,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   owner
);
    localparam int PW = $clog2(N);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_HOLD} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    logic          found;

    // First set request scanning upward from ptr, wrapping at N.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            owner <= '0;
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        owner <= pick;
                        gnt   <= N'(1) << pick;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Commit is unconditional: req is not consulted here.
                    q   <= wdata[owner*WIDTH +: WIDTH];
                    ack <= N'(1) << owner;
                    ptr <= (owner == PW'(N-1)) ? '0 : owner + 1'b1;
                    if (HOLD == 0) begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= CW'(HOLD - 1);
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench: one DUT with HOLD=2, one with HOLD=0 for back-to-back writes.
module tb_shared_reg_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0, req0 = '0;
    logic [31:0] wdata = '0, wdata0 = '0;
    logic [3:0]  gnt, ack, gnt0, ack0;
    logic [7:0]  q, q0;
    logic        busy, busy0;
    logic [1:0]  owner, owner0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.N(4), .WIDTH(8), .HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy), .owner(owner));

    shared_reg_arbiter #(.N(4), .WIDTH(8), .HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .wdata(wdata0),
        .gnt(gnt0), .ack(ack0), .q(q0), .busy(busy0), .owner(owner0));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        step();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
        total++; if (gnt !== 4'b0000 || ack !== 4'b0000) begin bad++; $display("FAIL reset_gnt_ack got=%b/%b exp=0000/0000", gnt, ack); end
        total++; if (busy !== 1'b0 || owner !== 2'd0) begin bad++; $display("FAIL reset_busy_owner got=%b/%0d exp=0/0", busy, owner); end
        total++; if (gnt0 !== 4'b0000 || q0 !== 8'h00) begin bad++; $display("FAIL reset_dut0 got=%b/%h exp=0000/00", gnt0, q0); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        wdata[15:8] = 8'hA5;
        req = 4'b0010;
        step();
        total++; if (gnt !== 4'b0010 || owner !== 2'd1) begin bad++; $display("FAIL single_gnt got=%b/%0d exp=0010/1", gnt, owner); end
        total++; if (ack !== 4'b0000 || busy !== 1'b1 || q !== 8'h00) begin bad++; $display("FAIL single_wr_cycle got=%b/%b/%h exp=0000/1/00", ack, busy, q); end
        step();
        total++; if (q !== 8'hA5 || ack !== 4'b0010) begin bad++; $display("FAIL single_ack got=%h/%b exp=a5/0010", q, ack); end
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt_ack_overlap got=%b exp=0010", gnt); end
        req = '0;
        step();
        total++; if (ack !== 4'b0000 || gnt !== 4'b0010 || busy !== 1'b1) begin bad++; $display("FAIL single_hold got=%b/%b/%b exp=0000/0010/1", ack, gnt, busy); end
        step();
        total++; if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'hA5) begin bad++; $display("FAIL single_release got=%b/%b/%h exp=0000/0/a5", gnt, busy, q); end
    endtask

    task automatic test_all_four;
        logic [7:0] d [4];
        logic [3:0] eg;
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        wdata = {d[3], d[2], d[1], d[0]};
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            eg = 4'b0001 << g;
            step();
            total++; if (gnt !== eg || owner !== 2'(g)) begin bad++; $display("FAIL all4_gnt%0d got=%b/%0d exp=%b/%0d", g, gnt, owner, eg, g); end
            step();
            total++; if (ack !== eg || q !== d[g]) begin bad++; $display("FAIL all4_ack%0d got=%b/%h exp=%b/%h", g, ack, q, eg, d[g]); end
            step();
            total++; if (ack !== 4'b0000) begin bad++; $display("FAIL all4_ack_pulse%0d got=%b exp=0000", g, ack); end
            step();
            total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL all4_idle%0d got=%b/%b exp=0000/0", g, gnt, busy); end
        end
        req = '0;
        step();
        total++; if (q !== 8'h44 || gnt !== 4'b0000) begin bad++; $display("FAIL all4_final got=%h/%b exp=44/0000", q, gnt); end
    endtask

    task automatic test_fairness;
        int ord [4];
        ord = '{0, 2, 0, 2};
        wdata[7:0]   = 8'h10;
        wdata[23:16] = 8'h30;
        req = 4'b0101;
        for (int r = 0; r < 4; r++) begin
            step();
            total++; if (owner !== 2'(ord[r]) || gnt !== (4'b0001 << ord[r])) begin bad++; $display("FAIL fair_order%0d got=%0d/%b exp=%0d", r, owner, gnt, ord[r]); end
            step();
            step();
            step();
        end
        req = '0;
        step();
    endtask

    task automatic test_drop_during_write;
        wdata[23:16] = 8'h5A;
        req = 4'b0100;
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drop_gnt got=%b exp=0100", gnt); end
        req = '0;
        step();
        total++; if (q !== 8'h5A || ack !== 4'b0100) begin bad++; $display("FAIL drop_commit got=%h/%b exp=5a/0100", q, ack); end
        step();
        step();
        step();
        step();
        total++; if (gnt !== 4'b0000 || busy !== 1'b0 || ack !== 4'b0000) begin bad++; $display("FAIL drop_no_regrant got=%b/%b/%b exp=0000/0/0000", gnt, busy, ack); end
    endtask

    task automatic test_back_to_back;
        req0 = 4'b1000;
        for (int j = 0; j < 3; j++) begin
            wdata0[31:24] = 8'hC0 + 8'(j);
            step();
            total++; if (gnt0 !== 4'b1000 || ack0 !== 4'b0000) begin bad++; $display("FAIL b2b_gnt%0d got=%b/%b exp=1000/0000", j, gnt0, ack0); end
            step();
            total++; if (gnt0 !== 4'b0000 || ack0 !== 4'b1000 || q0 !== 8'hC0 + 8'(j)) begin bad++; $display("FAIL b2b_ack%0d got=%b/%b/%h exp=0000/1000/%h", j, gnt0, ack0, q0, 8'hC0 + 8'(j)); end
        end
        req0 = '0;
        step();
    endtask

    task automatic test_reset_mid_op;
        wdata[7:0] = 8'h77;
        req = 4'b0001;
        step();
        total++; if (gnt !== 4'b0001 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_gnt got=%b/%b exp=0001/1", gnt, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (q !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0 || ack !== 4'b0000) begin bad++; $display("FAIL rstmid_async got=%h/%b/%b/%b exp=00/0000/0/0000", q, gnt, busy, ack); end
        req = '0;
        step();
        total++; if (ack !== 4'b0000 || q !== 8'h00) begin bad++; $display("FAIL rstmid_no_ack got=%b/%h exp=0000/00", ack, q); end
        wdata[31:24] = 8'hE7;
        req = 4'b1000;
        rst_n = 1'b1;
        step();
        total++; if (gnt !== 4'b1000 || owner !== 2'd3) begin bad++; $display("FAIL rstmid_regrant got=%b/%0d exp=1000/3", gnt, owner); end
        req = '0;
        step();
        total++; if (q !== 8'hE7 || ack !== 4'b1000) begin bad++; $display("FAIL rstmid_commit got=%h/%b exp=e7/1000", q, ack); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_drop_during_write();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
